// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: queues fetch-time predictions, checks them against C/Z flags,
// trains the predictor and flushes/redirects on a mispredict. Define BRU_STATS_EN for resolve/mispredict counters.
`default_nettype none

module branch_resolve_unit #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       BRU_CLK,
    input  logic       BRU_RST_N,
    input  logic       BRU_PUSH,
    input  logic [9:0] BRU_PUSH_ADDR,
    input  logic [9:0] BRU_PUSH_TARGET,
    input  logic       BRU_PUSH_PRED,
    output logic       BRU_FULL,
    input  logic       BRU_EX_VALID,
    input  logic [4:0] BRU_EX_OPCODE_HI_5,
    input  logic [1:0] BRU_EX_OPCODE_LO_2,
    input  logic       BRU_C_FLAG,
    input  logic       BRU_Z_FLAG,
    output logic       BRU_DECODE_COND_BRN,
    output logic       BRU_TAKE_COND_BRN,
    output logic [9:0] BRU_EVAL_BRN_ADDR,
    output logic       BRU_FLUSH,
    output logic       BRU_REDIRECT,
    output logic [9:0] BRU_REDIRECT_ADDR,
    output logic       BRU_ERR
`ifdef BRU_STATS_EN
    ,
    output logic [15:0] BRU_RESOLVED_CNT,
    output logic [15:0] BRU_MISPRED_CNT
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [6:0] OP_BREQ = 7'b0010010;
    localparam logic [6:0] OP_BRNE = 7'b0010011;
    localparam logic [6:0] OP_BRCS = 7'b0010100;
    localparam logic [6:0] OP_BRCC = 7'b0010101;

    // Prediction queue storage; only the pointers and count are reset.
    logic [9:0] addr_mem   [DEPTH];
    logic [9:0] target_mem [DEPTH];
    logic       pred_mem   [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [0:0]    state_reg, state_next;
    logic [2:0]    flush_cnt_reg, flush_cnt_next;

    logic       strobe_reg;
    logic       take_reg;
    logic [9:0] eval_addr_reg;
    logic       redirect_reg;
    logic [9:0] redirect_addr_reg;
    logic       err_reg;

    logic [6:0] opcode;
    logic       is_branch;
    logic       taken;
    logic       full;
    logic       empty;
    logic       in_idle;
    logic       ex_active;
    logic       push_active;
    logic       resolve;
    logic       mispredict;
    logic       push_accept;
    logic       err_set;
    logic [9:0] head_addr;
    logic [9:0] head_target;
    logic       head_pred;
    logic [9:0] redirect_target;

    assign opcode      = {BRU_EX_OPCODE_HI_5, BRU_EX_OPCODE_LO_2};
    assign full        = (count_reg == CW'(DEPTH));
    assign empty       = (count_reg == '0);
    assign in_idle     = (state_reg == ST_IDLE);
    assign ex_active   = in_idle & BRU_EX_VALID;
    assign push_active = in_idle & BRU_PUSH;

    assign head_addr   = addr_mem[rd_ptr_reg];
    assign head_target = target_mem[rd_ptr_reg];
    assign head_pred   = pred_mem[rd_ptr_reg];

    always_comb begin
        is_branch = 1'b1;
        taken     = 1'b0;
        case (opcode)
            OP_BREQ: taken = BRU_Z_FLAG;
            OP_BRNE: taken = ~BRU_Z_FLAG;
            OP_BRCS: taken = BRU_C_FLAG;
            OP_BRCC: taken = ~BRU_C_FLAG;
            default: is_branch = 1'b0;
        endcase
    end

    assign resolve     = ex_active & ~empty & is_branch;
    assign mispredict  = resolve & (taken != head_pred);
    // A push alongside a mispredict is a wrong-path branch; a pop frees a slot even when full.
    assign push_accept = push_active & ~mispredict & (~full | resolve);
    assign err_set     = (push_active & full & ~resolve)
                       | (ex_active & empty)
                       | (ex_active & ~is_branch);

    assign redirect_target = taken ? head_target : (head_addr + 10'd1);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge BRU_CLK) begin
                if (push_accept && (wr_ptr_reg == PW'(gi))) begin
                    addr_mem[gi]   <= BRU_PUSH_ADDR;
                    target_mem[gi] <= BRU_PUSH_TARGET;
                    pred_mem[gi]   <= BRU_PUSH_PRED;
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (mispredict) begin
            rd_ptr_next = wr_ptr_reg;
            count_next  = '0;
        end else begin
            if (push_accept) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (resolve) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push_accept, resolve})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mispredict) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = 3'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_reg == 3'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 3'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge BRU_CLK or negedge BRU_RST_N) begin
        if (!BRU_RST_N) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            state_reg         <= ST_IDLE;
            flush_cnt_reg     <= '0;
            strobe_reg        <= 1'b0;
            take_reg          <= 1'b0;
            eval_addr_reg     <= '0;
            redirect_reg      <= 1'b0;
            redirect_addr_reg <= '0;
            err_reg           <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            strobe_reg    <= resolve;
            redirect_reg  <= mispredict;
            if (resolve) begin
                take_reg      <= taken;
                eval_addr_reg <= head_addr;
            end
            if (mispredict) begin
                redirect_addr_reg <= redirect_target;
            end
            if (err_set) begin
                err_reg <= 1'b1;
            end
        end
    end

`ifdef BRU_STATS_EN
    logic [15:0] resolved_cnt_reg;
    logic [15:0] mispred_cnt_reg;

    always_ff @(posedge BRU_CLK or negedge BRU_RST_N) begin
        if (!BRU_RST_N) begin
            resolved_cnt_reg <= '0;
            mispred_cnt_reg  <= '0;
        end else begin
            if (resolve && (resolved_cnt_reg != 16'hFFFF)) begin
                resolved_cnt_reg <= resolved_cnt_reg + 16'd1;
            end
            if (mispredict && (mispred_cnt_reg != 16'hFFFF)) begin
                mispred_cnt_reg <= mispred_cnt_reg + 16'd1;
            end
        end
    end

    assign BRU_RESOLVED_CNT = resolved_cnt_reg;
    assign BRU_MISPRED_CNT  = mispred_cnt_reg;
`endif

    assign BRU_FULL            = full;
    assign BRU_DECODE_COND_BRN = strobe_reg;
    assign BRU_TAKE_COND_BRN   = take_reg;
    assign BRU_EVAL_BRN_ADDR   = eval_addr_reg;
    assign BRU_FLUSH           = (state_reg == ST_FLUSH);
    assign BRU_REDIRECT        = redirect_reg;
    assign BRU_REDIRECT_ADDR   = redirect_addr_reg;
    assign BRU_ERR             = err_reg;

endmodule

`default_nettype wire
